// File: rtl/lbp_pkg.sv
// Shared geometry, FSM state type and border test for the LBP frame host.
package lbp_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int PIX_CNT   = IMG_W * IMG_H;
  localparam int INNER_CNT = (IMG_W - 2) * (IMG_H - 2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Row/col split is a shift/mask once w is a power of two and constant.
  function automatic logic is_border(input int addr, input int w = IMG_W, input int h = IMG_H);
    int row;
    int col;
    row = addr / w;
    col = addr % w;
    return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
  endfunction

endpackage

// File: rtl/lbp_frame_ram.sv
// Frame store: one synchronous write port, one asynchronous read port.
module lbp_frame_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lbp_frame_host.sv
// Host responder for the LBP engine: loads the gray frame, serves engine reads,
// captures engine writes and streams the result frame out with zeroed borders.
//
// state | meaning
// LOAD  | accept raster pixels into gray_mem
// SERVE | serve gray reads, capture lbp writes until finish
// DRAIN | stream the result frame, border pixels forced to zero
module lbp_frame_host #(
  parameter int IMG_W  = lbp_pkg::IMG_W,
  parameter int IMG_H  = lbp_pkg::IMG_H,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [7:0]        gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic              res_valid,
  output logic [7:0]        res_data,
  output logic              res_last,
  input  logic              res_ready,
  output logic              err_border,
  output logic              err_count
);
  import lbp_pkg::*;

  localparam int                PIX       = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);
  localparam logic [14:0]       INNER_W   = 15'((IMG_W - 2) * (IMG_H - 2));
  localparam logic [14:0]       WR_SAT    = 15'h7FFF;

  state_e            state_q;
  logic [ADDR_W-1:0] ld_cnt_q;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic [14:0]       wr_cnt_q;
  logic [14:0]       wr_cnt_d;
  logic              rd_done_q;
  logic              gray_ready_q;
  logic              res_valid_q;
  logic              res_last_q;
  logic [7:0]        res_data_q;
  logic              err_border_q;
  logic              err_count_q;

  logic              gray_we;
  logic              res_we;
  logic              lbp_border;
  logic              rd_border;
  logic [7:0]        gray_rdata;
  logic [7:0]        res_rdata;
  logic [7:0]        drain_pix;

  assign lbp_border = is_border(32'(lbp_addr), IMG_W, IMG_H);
  assign rd_border  = is_border(32'(rd_cnt_q), IMG_W, IMG_H);

  assign gray_we   = (state_q == LOAD) && pix_valid;
  assign res_we    = (state_q == SERVE) && lbp_valid && !lbp_border;
  assign wr_cnt_d  = (res_we && (wr_cnt_q != WR_SAT)) ? wr_cnt_q + 15'd1 : wr_cnt_q;
  assign drain_pix = rd_border ? 8'h00 : res_rdata;

  lbp_frame_ram #(.ADDR_W(ADDR_W), .DATA_W(8)) gray_mem (
    .clk     (clk),
    .we_i    (gray_we),
    .waddr_i (ld_cnt_q),
    .wdata_i (pix_data),
    .raddr_i (gray_addr),
    .rdata_o (gray_rdata)
  );

  lbp_frame_ram #(.ADDR_W(ADDR_W), .DATA_W(8)) res_mem (
    .clk     (clk),
    .we_i    (res_we),
    .waddr_i (lbp_addr),
    .wdata_i (lbp_data),
    .raddr_i (rd_cnt_q),
    .rdata_o (res_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      ld_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      rd_done_q    <= 1'b0;
      gray_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_last_q   <= 1'b0;
      res_data_q   <= '0;
      err_border_q <= 1'b0;
      err_count_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (pix_valid) begin
            if (ld_cnt_q == LAST_ADDR) begin
              ld_cnt_q     <= '0;
              gray_ready_q <= 1'b1;
              state_q      <= SERVE;
            end else begin
              ld_cnt_q <= ld_cnt_q + ADDR_W'(1);
            end
          end
        end
        SERVE: begin
          wr_cnt_q <= wr_cnt_d;
          if (lbp_valid && lbp_border) err_border_q <= 1'b1;
          // A write landing with finish is counted before the count is judged.
          if (finish) begin
            err_count_q  <= (wr_cnt_d != INNER_W);
            gray_ready_q <= 1'b0;
            state_q      <= DRAIN;
          end
        end
        DRAIN: begin
          if (res_valid_q && res_ready && res_last_q) begin
            res_valid_q  <= 1'b0;
            res_last_q   <= 1'b0;
            rd_cnt_q     <= '0;
            rd_done_q    <= 1'b0;
            wr_cnt_q     <= '0;
            err_border_q <= 1'b0;
            err_count_q  <= 1'b0;
            state_q      <= LOAD;
          end else if (!rd_done_q && (!res_valid_q || res_ready)) begin
            res_valid_q <= 1'b1;
            res_data_q  <= drain_pix;
            res_last_q  <= (rd_cnt_q == LAST_ADDR);
            rd_done_q   <= (rd_cnt_q == LAST_ADDR);
            rd_cnt_q    <= rd_cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign pix_ready  = (state_q == LOAD);
  assign gray_ready = gray_ready_q;
  assign gray_data  = ((state_q == SERVE) && gray_req) ? gray_rdata : 8'h00;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_last   = res_last_q;
  assign err_border = err_border_q;
  assign err_count  = err_count_q;

endmodule

// File: doc/lbp_frame_host.md
# lbp_frame_host

Host-side responder for the LBP engine's two memory interfaces. It loads a 128×128 grayscale frame from a raster pixel stream and serves it on the `gray_*` read interface. It captures the engine's `lbp_*` writes into a result frame and, on `finish`, streams the full result frame out with border pixels forced to zero. It sits between the system data path and the LBP engine, and replaces the testbench memory models in integrated builds.

## Interface
Parameters:
- `IMG_W`, default 128: image width in pixels.
- `IMG_H`, default 128: image height in pixels.
- `ADDR_W`, default 14: address width; must satisfy `2**ADDR_W == IMG_W*IMG_H`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pix_valid`  in  1  input pixel beat valid.
- `pix_data`  in  8  input pixel, raster order.
- `pix_ready`  out  1  host accepts a pixel.
- `gray_ready`  out  1  frame loaded; engine may start.
- `gray_req`  in  1  engine read request.
- `gray_addr`  in  ADDR_W  engine read address.
- `gray_data`  out  8  read data, combinational from `gray_addr`.
- `lbp_valid`  in  1  engine write strobe.
- `lbp_addr`  in  ADDR_W  engine write address.
- `lbp_data`  in  8  engine write data.
- `finish`  in  1  engine done pulse.
- `res_valid`  out  1  result beat valid.
- `res_data`  out  8  result pixel, raster order.
- `res_last`  out  1  final result beat (address `IMG_W*IMG_H-1`).
- `res_ready`  in  1  downstream accepts a result beat.
- `err_border`  out  1  sticky; the engine attempted a write to a border address.
- `err_count`  out  1  sticky; `finish` arrived with the inner write count not equal to `(IMG_W-2)*(IMG_H-2)`.

## Operation
- FSM states:
  - LOAD: `pix_ready=1`; each accepted beat writes `gray_mem[ld_cnt]` and increments `ld_cnt`. On the accepted beat with `ld_cnt == IMG_W*IMG_H-1`, go to SERVE and clear `ld_cnt`.
  - SERVE: `gray_ready=1`.
    - `gray_data = gray_mem[gray_addr]` while `gray_req` is high; otherwise 0.
    - On the `lbp_valid` edge with a non-border `lbp_addr`: write `res_mem[lbp_addr] <= lbp_data` and increment `wr_cnt`.
    - On a border `lbp_addr`: drop the write and set `err_border`.
    - On the `finish` edge: set `err_count` if `wr_cnt != 15876`, then go to DRAIN.
  - DRAIN: raster read-out at `rd_cnt` from 0 to 16383. Border addresses output 0x00; inner addresses output `res_mem[rd_cnt]`. When the last beat is accepted, go to LOAD, clear `wr_cnt`, clear `rd_cnt`, and clear both error flags.
- Border test: row = `addr[13:7]`, col = `addr[6:0]`. The address is a border address if row or col equals 0 or 127.
- Events ignored outside their state: `pix_valid` outside LOAD, `lbp_valid`/`finish` outside SERVE, `res_ready` outside DRAIN.
- Simultaneous `lbp_valid` and `finish` in SERVE: perform the write first, then evaluate `err_count` on the updated count.
- `wr_cnt` is 15 bits wide and saturates at 0x7FFF. Duplicate writes to the same address are counted.
- `res_mem` is not cleared between frames. Every inner address is overwritten in a correct run.

## Timing
- Reset (low) behaviour:
  - Applies immediately: state LOAD, all counters 0, `gray_ready=0`, `res_valid=0`, `res_last=0`, `err_border=0`, `err_count=0`, `pix_ready=1` (after the release of reset).
  - `gray_data` outputs 0.
  - Memory contents are not reset.
  - Reset mid-operation discards the frame and restarts from LOAD.
- `gray_ready` is registered and rises on the edge that accepts the 16384th pixel. It falls on the edge that samples `finish`, so an engine that returns to its idle state after `finish` sees `gray_ready=0`.
- Read latency is zero: `gray_data` is valid in the same cycle as `gray_addr`, before the next rising edge.
- Result stream:
  - `res_valid`/`res_data`/`res_last` are registered.
  - The first beat is valid one cycle after entering DRAIN.
  - Data is held stable while `res_valid && !res_ready`.
  - One beat per cycle under continuous `res_ready`.

## Structure
- Package `lbp_pkg`: `IMG_W`, `IMG_H`, `PIX_CNT=16384`, `INNER_CNT=15876`, state enum {LOAD, SERVE, DRAIN}, function `is_border(addr)`.
- Sub-module `lbp_frame_ram`: 8-bit × `2**ADDR_W`, one synchronous write port and one asynchronous read port. Instantiate it twice: `gray_mem` and `res_mem`.

## Test plan
- Load a ramp frame (`pix=addr[7:0]`) → `gray_ready` goes high exactly after the 16384th beat; `gray_addr=129` with `gray_req=1` gives `gray_data=0x81`; `gray_req=0` gives 0x00.
- Engine writes all 15876 inner addresses with `data=addr[7:0]`, then `finish` → 16384 result beats; addr 0 → 0x00, addr 129 → 0x81, addr 16383 → 0x00 with `res_last=1`; both error flags 0.
- Write `lbp_addr=0x0005`, `lbp_data=0xFF` → `err_border=1`; result addr 5 = 0x00; `wr_cnt` unchanged.
- `finish` after 10 writes → `err_count=1`; DRAIN still outputs 16384 beats.
- `res_ready` toggling every other cycle → `res_data` stable during stalls; exactly 16384 accepted beats; `res_last` only on the final beat.
- `reset` low mid-SERVE → `gray_ready=0` immediately; after release `pix_ready=1`, and a fresh 16384-beat load re-enters SERVE.
